// File: rtl/osiris_mem_pkg.sv
// rtl/osiris_mem_pkg.sv - shared funct3 codes, FSM states and access-check helpers
package osiris_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_state_e;

  // Halves need an even address and words a 4-byte-aligned address.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] adr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = adr_lo[0];
      F3_W:        mis = (adr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic ill;
    if (we) begin
      ill = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
    end else begin
      ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    return ill;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and lane select/extension for loads
module mem_lane_align
  import osiris_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rd_word_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    st_be_o   = 4'b0000;
    st_data_o = 32'h0000_0000;
    case (funct3_i)
      F3_B: begin
        st_be_o   = 4'b0001 << lane_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      F3_H: begin
        st_be_o   = lane_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{st_data_i[15:0]}};
      end
      F3_W: begin
        st_be_o   = 4'b1111;
        st_data_o = st_data_i;
      end
      default: begin
        st_be_o   = 4'b0000;
        st_data_o = 32'h0000_0000;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'h00;
    case (lane_i)
      2'd0:    ld_byte = rd_word_i[7:0];
      2'd1:    ld_byte = rd_word_i[15:8];
      2'd2:    ld_byte = rd_word_i[23:16];
      default: ld_byte = rd_word_i[31:24];
    endcase
    ld_half = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
  end

  always_comb begin
    ld_data_o = 32'h0000_0000;
    case (funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h00_0000, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0000, ld_half};
      F3_W:    ld_data_o = rd_word_i;
      default: ld_data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/wb_byte_ram.sv
// rtl/wb_byte_ram.sv - Wishbone byte-addressable data RAM with RV32 load/store sizing and wait states
module wb_byte_ram
  import osiris_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_SIZE_BYTES = 1024,
  parameter int WAIT_STATES    = 0,
  parameter int ADDR_WIDTH     = $clog2(MEM_SIZE_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  busy_o
);

  localparam int         WORDS   = MEM_SIZE_BYTES / 4;
  localparam bit         NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("wb_byte_ram: DATA_WIDTH must be 32");
  end
  if ((MEM_SIZE_BYTES < 8) || ((MEM_SIZE_BYTES & (MEM_SIZE_BYTES - 1)) != 0)) begin : g_bad_size
    $error("wb_byte_ram: MEM_SIZE_BYTES must be a power of 2 and at least 8");
  end
  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait
    $error("wb_byte_ram: WAIT_STATES must be in 0..15");
  end
  if (ADDR_WIDTH != $clog2(MEM_SIZE_BYTES)) begin : g_bad_addr
    $error("wb_byte_ram: ADDR_WIDTH must not be overridden");
  end

  mem_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  req_err;
  logic                  wr_en;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata;
  logic [31:0]           ld_data;
  logic [31:0]           rd_word;
  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  assign req_err = is_misaligned(f3_q, adr_q[1:0]) || is_illegal(we_q, f3_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i;
          dat_d   = wb_dat_i;
          we_d    = wb_we_i;
          f3_d    = funct3;
          state_d = CAPT;
        end
      end
      CAPT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (NO_WAIT) begin
          state_d = RESP;
        end else begin
          cnt_d   = WS_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The response flags are registered on entry to RESP so they last exactly that one cycle.
  always_comb begin
    ack_d = (state_d == RESP) && !req_err;
    err_d = (state_d == RESP) && req_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  mem_lane_align u_align (
    .funct3_i  (f3_q),
    .lane_i    (adr_q[1:0]),
    .st_data_i (dat_q),
    .rd_word_i (rd_word),
    .st_be_o   (st_be),
    .st_data_o (st_wdata),
    .ld_data_o (ld_data)
  );

  assign rd_word = mem_q[adr_q[ADDR_WIDTH-1:2]];
  assign wr_en   = (state_q == RESP) && ack_q && we_q;

  // No reset on the array: contents survive rst, and only a RESP-cycle store commits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem_q[adr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= st_wdata[8*i +: 8];
        end
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = (ack_q && !we_q) ? ld_data : '0;
  assign busy_o   = (state_q == CAPT) || (state_q == WAIT);

endmodule

// File: tb/tb_wb_byte_ram.sv
// tb/tb_wb_byte_ram.sv - directed self-checking bench for wb_byte_ram at 0 and 3 wait states
module tb_wb_byte_ram;

  logic        clk;
  logic        rst;

  logic [9:0]  adr0, adr3;
  logic [31:0] wdat0, wdat3;
  logic        we0, we3, stb0, stb3, cyc0, cyc3;
  logic [2:0]  f30, f33;
  logic [31:0] rdat0, rdat3;
  logic        ack0, ack3, err0, err3, busy0, busy3;

  int tests;
  int fails;

  wb_byte_ram #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst),
    .wb_adr_i(adr0), .wb_dat_i(wdat0), .wb_we_i(we0), .wb_stb_i(stb0), .wb_cyc_i(cyc0),
    .funct3(f30), .wb_dat_o(rdat0), .wb_ack_o(ack0), .wb_err_o(err0), .busy_o(busy0)
  );

  wb_byte_ram #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst),
    .wb_adr_i(adr3), .wb_dat_i(wdat3), .wb_we_i(we3), .wb_stb_i(stb3), .wb_cyc_i(cyc3),
    .funct3(f33), .wb_dat_o(rdat3), .wb_ack_o(ack3), .wb_err_o(err3), .busy_o(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic cyc, input logic stb, input logic we,
                       input logic [2:0] f3, input logic [9:0] adr, input logic [31:0] dat);
    if (sel == 0) begin
      cyc0 = cyc; stb0 = stb; we0 = we; f30 = f3; adr0 = adr; wdat0 = dat;
    end else begin
      cyc3 = cyc; stb3 = stb; we3 = we; f33 = f3; adr3 = adr; wdat3 = dat;
    end
  endtask

  function automatic logic g_ack(input int sel);
    return (sel == 0) ? ack0 : ack3;
  endfunction
  function automatic logic g_err(input int sel);
    return (sel == 0) ? err0 : err3;
  endfunction
  function automatic logic g_busy(input int sel);
    return (sel == 0) ? busy0 : busy3;
  endfunction
  function automatic logic [31:0] g_dat(input int sel);
    return (sel == 0) ? rdat0 : rdat3;
  endfunction

  // Called at a negedge; returns at a negedge one cycle after the response.
  task automatic do_op(input string tag, input int sel, input logic we, input logic [2:0] f3,
                       input logic [9:0] adr, input logic [31:0] dat, input bit keep,
                       input bit exp_ok, input logic [31:0] exp_rd);
    int n, t0, lat, nbusy, ws;
    bit done;
    logic ack, err;
    logic [31:0] rd;
    ws = (sel == 0) ? 0 : 3;
    n = 0; t0 = -1; lat = -1; nbusy = 0; done = 0; ack = 0; err = 0; rd = '0;
    drive(sel, 1'b1, 1'b1, we, f3, adr, dat);
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (g_busy(sel)) begin
        nbusy++;
        if (t0 < 0) t0 = n;
      end
      if (g_ack(sel) || g_err(sel)) begin
        done = 1;
        ack  = g_ack(sel);
        err  = g_err(sel);
        rd   = g_dat(sel);
        if (t0 >= 0) lat = n - t0 + 1;
      end
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".ack"}, 32'(ack), 32'(exp_ok));
    chk({tag, ".err"}, 32'(err), 32'(!exp_ok));
    chk({tag, ".lat"}, 32'(lat), 32'(2 + ws));
    chk({tag, ".busy"}, 32'(nbusy), 32'(1 + ws));
    if (!we) chk({tag, ".dat"}, rd, exp_ok ? exp_rd : 32'h0);
    if (!keep) drive(sel, 1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".pulse"}, {30'h0, g_ack(sel), g_err(sel)}, 32'h0);
  endtask

  initial begin
    bit seen;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 32'h0);
    drive(3, 1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 32'h0);
    #1;
    chk("rst.out0", {rdat0[28:0], ack0, err0, busy0}, 32'h0);
    chk("rst.out3", {rdat3[28:0], ack3, err3, busy3}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Zero wait states: sizing, extension, errors and the top byte.
    do_op("sw10",   0, 1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 0, 1, 32'h0);
    do_op("lw10",   0, 1'b0, 3'b010, 10'h010, 32'h0,        0, 1, 32'hDEADBEEF);
    do_op("sb13",   0, 1'b1, 3'b000, 10'h013, 32'h0000007F, 0, 1, 32'h0);
    do_op("sb12",   0, 1'b1, 3'b000, 10'h012, 32'h00000080, 0, 1, 32'h0);
    do_op("lw10b",  0, 1'b0, 3'b010, 10'h010, 32'h0,        0, 1, 32'h7F80BEEF);
    do_op("lb12",   0, 1'b0, 3'b000, 10'h012, 32'h0,        0, 1, 32'hFFFFFF80);
    do_op("lbu12",  0, 1'b0, 3'b100, 10'h012, 32'h0,        0, 1, 32'h00000080);
    do_op("lh12",   0, 1'b0, 3'b001, 10'h012, 32'h0,        0, 1, 32'h00007F80);
    do_op("lh10",   0, 1'b0, 3'b001, 10'h010, 32'h0,        0, 1, 32'hFFFFBEEF);
    do_op("lhu10",  0, 1'b0, 3'b101, 10'h010, 32'h0,        0, 1, 32'h0000BEEF);
    do_op("sh11",   0, 1'b1, 3'b001, 10'h011, 32'h00001234, 0, 0, 32'h0);
    do_op("sst100", 0, 1'b1, 3'b100, 10'h010, 32'h00000000, 0, 0, 32'h0);
    do_op("lw10c",  0, 1'b0, 3'b010, 10'h010, 32'h0,        0, 1, 32'h7F80BEEF);
    do_op("lw16",   0, 1'b0, 3'b010, 10'h016, 32'h0,        0, 0, 32'h0);
    do_op("ld011",  0, 1'b0, 3'b011, 10'h010, 32'h0,        0, 0, 32'h0);
    do_op("sw3fc",  0, 1'b1, 3'b010, 10'h3FC, 32'h01020304, 0, 1, 32'h0);
    do_op("sb3ff",  0, 1'b1, 3'b000, 10'h3FF, 32'h000000A5, 0, 1, 32'h0);
    do_op("lbu3ff", 0, 1'b0, 3'b100, 10'h3FF, 32'h0,        0, 1, 32'h000000A5);
    do_op("lb3ff",  0, 1'b0, 3'b000, 10'h3FF, 32'h0,        0, 1, 32'hFFFFFFA5);
    do_op("b2b.a",  0, 1'b0, 3'b010, 10'h010, 32'h0,        1, 1, 32'h7F80BEEF);
    do_op("b2b.b",  0, 1'b0, 3'b010, 10'h3FC, 32'h0,        0, 1, 32'hA5020304);

    // Three wait states: latency, abort on cyc drop.
    do_op("w3.sw40", 3, 1'b1, 3'b010, 10'h040, 32'hCAFEF00D, 0, 1, 32'h0);
    do_op("w3.lw40", 3, 1'b0, 3'b010, 10'h040, 32'h0,        0, 1, 32'hCAFEF00D);
    drive(3, 1'b1, 1'b1, 1'b1, 3'b010, 10'h040, 32'h0BADBEEF);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    drive(3, 1'b0, 1'b1, 1'b1, 3'b010, 10'h040, 32'h0BADBEEF);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack3 || err3) seen = 1;
    end
    chk("abort.noresp", 32'(seen), 32'd0);
    chk("abort.idle", 32'(busy3), 32'd0);
    drive(3, 1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 32'h0);
    @(negedge clk);
    do_op("w3.lw40b", 3, 1'b0, 3'b010, 10'h040, 32'h0, 0, 1, 32'hCAFEF00D);

    // Reset while a store sits in WAIT.
    do_op("w3.sw20", 3, 1'b1, 3'b010, 10'h020, 32'h11223344, 0, 1, 32'h0);
    drive(3, 1'b1, 1'b1, 1'b1, 3'b010, 10'h020, 32'h12345678);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rstw.busy_before", 32'(busy3), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstw.outs", {rdat3[28:0], ack3, err3, busy3}, 32'h0);
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    do_op("w3.lw20", 3, 1'b0, 3'b010, 10'h020, 32'h0, 0, 1, 32'h11223344);
    do_op("lw10d",   0, 1'b0, 3'b010, 10'h010, 32'h0, 0, 1, 32'h7F80BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
